// File: rtl/ifu_fetch.sv
// Instruction fetch unit: takes one PC, issues a single imem read and hands the
// tagged instruction (word, PC, fault code) to decode. One fetch in flight at most.
//
// state | meaning
// IDLE  | ready for a new PC
// REQ   | read request on the bus, waiting for grant
// WAIT  | granted, waiting for rvalid or timeout
// OUT   | instruction presented to decode
// DRAIN | flushed after grant; swallow the response or timeout
module ifu_fetch #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [1:0]  inst_fault_o
);

    localparam int unsigned     TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_ALIGN   = 2'd1;
    localparam logic [1:0] FLT_BUS     = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q;
    logic [31:0]   addr_q;
    logic [31:0]   inst_q;
    logic [1:0]    fault_q;
    logic          accept;
    logic          misaligned;
    logic          timer_done;

    assign accept     = pc_ready_o & pc_valid_i;
    assign misaligned = (pc_i[1:0] != 2'b00);
    assign timer_done = (timer_q == T_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = misaligned ? S_OUT : S_REQ;
                end
            end
            S_REQ: begin
                if (imem_gnt_i) begin
                    state_d = flush_i ? S_DRAIN : S_WAIT;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // a flush coinciding with the response/timeout has nothing left to drain
                if (flush_i) begin
                    state_d = (imem_rvalid_i || timer_done) ? S_IDLE : S_DRAIN;
                end else if (imem_rvalid_i || timer_done) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (flush_i || inst_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid_i || timer_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_ready_o   = 1'b0;
        imem_req_o   = 1'b0;
        inst_valid_o = 1'b0;
        case (state_q)
            S_IDLE:  pc_ready_o   = rst & ~flush_i;
            S_REQ:   imem_req_o   = 1'b1;
            S_OUT:   inst_valid_o = 1'b1;
            default: ;
        endcase
    end

    // timer saturates at its terminal count so a long drain never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= '0;
        end else if (state_q == S_REQ && imem_gnt_i) begin
            timer_q <= '0;
        end else if ((state_q == S_WAIT || state_q == S_DRAIN) && !timer_done) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            inst_q  <= NOP_INST;
            fault_q <= FLT_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q <= pc_i;
                        if (misaligned) begin
                            inst_q  <= NOP_INST;
                            fault_q <= FLT_ALIGN;
                        end
                    end
                end
                S_WAIT: begin
                    if (!flush_i) begin
                        if (imem_rvalid_i) begin
                            inst_q  <= imem_err_i ? NOP_INST : imem_rdata_i;
                            fault_q <= imem_err_i ? FLT_BUS : FLT_NONE;
                        end else if (timer_done) begin
                            inst_q  <= NOP_INST;
                            fault_q <= FLT_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr_o  = addr_q;
    assign inst_pc_o    = addr_q;
    assign inst_o       = inst_q;
    assign inst_fault_o = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
module tb_ifu_fetch;

    localparam int unsigned TIMEOUT  = 16;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0;
    logic        pc_valid_i = 1'b0;
    logic        pc_ready_o;
    logic        flush_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_err_i = 1'b0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [1:0]  inst_fault_o;

    int n_vec = 0;
    int n_err = 0;

    ifu_fetch #(.TIMEOUT(TIMEOUT), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst),
        .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_fault_o(inst_fault_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: one fetch in flight, tracked as flags plus cycles since grant.
    bit          m_req, m_wait, m_drop, m_out;
    int          m_since;
    logic [31:0] m_pc, m_inst;
    logic [1:0]  m_fault;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req = 0; m_wait = 0; m_drop = 0; m_out = 0; m_since = 0;
            m_pc = '0; m_inst = NOP_INST; m_fault = 2'd0;
        end else if (m_out) begin
            if (flush_i || inst_ready_i) m_out = 0;
        end else if (m_req) begin
            if (imem_gnt_i) begin
                m_req = 0; m_wait = 1; m_drop = flush_i; m_since = 0;
            end else if (flush_i) begin
                m_req = 0;
            end
        end else if (m_wait) begin
            m_since = m_since + 1;
            if (flush_i) m_drop = 1;
            if (imem_rvalid_i || m_since == TIMEOUT) begin
                m_wait = 0;
                if (!m_drop) begin
                    m_out = 1;
                    if (!imem_rvalid_i) begin
                        m_fault = 2'd3; m_inst = NOP_INST;
                    end else if (imem_err_i) begin
                        m_fault = 2'd2; m_inst = NOP_INST;
                    end else begin
                        m_fault = 2'd0; m_inst = imem_rdata_i;
                    end
                end
            end
        end else if (pc_valid_i && !flush_i) begin
            m_pc = pc_i;
            if (pc_i[1:0] != 2'b00) begin
                m_out = 1; m_fault = 2'd1; m_inst = NOP_INST;
            end else begin
                m_req = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("pc_ready", {31'b0, pc_ready_o},
              {31'b0, rst && !(m_req || m_wait || m_out) && !flush_i});
        check("imem_req", {31'b0, imem_req_o}, {31'b0, m_req});
        check("inst_valid", {31'b0, inst_valid_o}, {31'b0, m_out});
        if (m_req) check("imem_addr", imem_addr_o, m_pc);
        if (m_out) begin
            check("inst", inst_o, m_inst);
            check("inst_pc", inst_pc_o, m_pc);
            check("inst_fault", {30'b0, inst_fault_o}, {30'b0, m_fault});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aligned_fetch(input logic [31:0] pc, input logic [31:0] data, input logic err);
        pc_i = pc; pc_valid_i = 1; step();
        pc_valid_i = 0; imem_gnt_i = 1;
        check("req_addr", imem_addr_o, pc);
        check("req_high", {31'b0, imem_req_o}, 32'd1);
        step();
        imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = data; imem_err_i = err; step();
        imem_rvalid_i = 0; imem_err_i = 0;
    endtask

    int rv_div;

    initial begin
        // reset
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_req", {31'b0, imem_req_o}, 32'd0);
            check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
            check("rst_pc_ready", {31'b0, pc_ready_o}, 32'd0);
        end
        check("rst_inst", inst_o, NOP_INST);
        check("rst_inst_pc", inst_pc_o, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_fault", {30'b0, inst_fault_o}, 32'd0);
        rst = 1; #1;
        check("pc_ready_after_rst", {31'b0, pc_ready_o}, 32'd1);

        // clean fetch
        aligned_fetch(32'h8000_0000, 32'h0010_0093, 1'b0);
        check("clean_valid", {31'b0, inst_valid_o}, 32'd1);
        check("clean_inst", inst_o, 32'h0010_0093);
        check("clean_pc", inst_pc_o, 32'h8000_0000);
        check("clean_fault", {30'b0, inst_fault_o}, 32'd0);
        inst_ready_i = 1; step(); inst_ready_i = 0;
        check("clean_done", {31'b0, inst_valid_o}, 32'd0);

        // misaligned PC
        pc_i = 32'h8000_0002; pc_valid_i = 1; step(); pc_valid_i = 0;
        check("mis_req", {31'b0, imem_req_o}, 32'd0);
        check("mis_valid", {31'b0, inst_valid_o}, 32'd1);
        check("mis_fault", {30'b0, inst_fault_o}, 32'd1);
        check("mis_inst", inst_o, 32'h0000_0013);
        inst_ready_i = 1; step(); inst_ready_i = 0;

        // bus error with backpressure
        aligned_fetch(32'h8000_0004, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("err_valid", {31'b0, inst_valid_o}, 32'd1);
            check("err_fault", {30'b0, inst_fault_o}, 32'd2);
            check("err_inst", inst_o, NOP_INST);
            check("err_pc", inst_pc_o, 32'h8000_0004);
            check("err_pc_ready", {31'b0, pc_ready_o}, 32'd0);
            step();
        end
        inst_ready_i = 1; step(); inst_ready_i = 0;

        // timeout, then a stray response
        pc_i = 32'h8000_0008; pc_valid_i = 1; step(); pc_valid_i = 0;
        imem_gnt_i = 1; step(); imem_gnt_i = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("to_valid", {31'b0, inst_valid_o}, (k == 16) ? 32'd1 : 32'd0);
        end
        check("to_fault", {30'b0, inst_fault_o}, 32'd3);
        check("to_inst", inst_o, NOP_INST);
        inst_ready_i = 1; step(); inst_ready_i = 0;
        step();
        imem_rvalid_i = 1; imem_rdata_i = 32'hCAFE_F00D; step(); imem_rvalid_i = 0;
        check("stray_valid", {31'b0, inst_valid_o}, 32'd0);
        check("stray_pc_ready", {31'b0, pc_ready_o}, 32'd1);

        // flush in WAIT, then a normal fetch
        pc_i = 32'h8000_000C; pc_valid_i = 1; step(); pc_valid_i = 0;
        imem_gnt_i = 1; step(); imem_gnt_i = 0;
        flush_i = 1; step(); flush_i = 0;
        check("drain_pc_ready", {31'b0, pc_ready_o}, 32'd0);
        step();
        imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF; step(); imem_rvalid_i = 0;
        check("flush_valid", {31'b0, inst_valid_o}, 32'd0);
        check("flush_idle", {31'b0, pc_ready_o}, 32'd1);
        aligned_fetch(32'h8000_0010, 32'h0020_0113, 1'b0);
        check("post_flush_inst", inst_o, 32'h0020_0113);
        check("post_flush_pc", inst_pc_o, 32'h8000_0010);
        inst_ready_i = 1; step(); inst_ready_i = 0;

        // async reset while presenting
        pc_i = 32'h8000_0001; pc_valid_i = 1; step(); pc_valid_i = 0;
        check("pre_rst_valid", {31'b0, inst_valid_o}, 32'd1);
        #3 rst = 0; #1;
        check("arst_valid", {31'b0, inst_valid_o}, 32'd0);
        check("arst_inst", inst_o, NOP_INST);
        check("arst_pc", inst_pc_o, 32'h0);
        check("arst_fault", {30'b0, inst_fault_o}, 32'd0);
        check("arst_addr", imem_addr_o, 32'h0);
        check("arst_pc_ready", {31'b0, pc_ready_o}, 32'd0);
        step(); step();
        rst = 1; #1;
        check("arst_release", {31'b0, pc_ready_o}, 32'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            case ((c / 500) % 3)
                0:       rv_div = 2;
                1:       rv_div = 8;
                default: rv_div = 40;
            endcase
            pc_valid_i    = ($urandom_range(1, 0) == 1);
            pc_i          = {$urandom(), 2'b00} | (($urandom_range(3, 0) == 0) ? 32'(1 + $urandom_range(2, 0)) : 32'd0);
            flush_i       = ($urandom_range(9, 0) == 0);
            imem_gnt_i    = ($urandom_range(1, 0) == 1);
            imem_rvalid_i = ($urandom_range(rv_div - 1, 0) == 0);
            imem_rdata_i  = $urandom();
            imem_err_i    = ($urandom_range(3, 0) == 0);
            inst_ready_i  = ($urandom_range(1, 0) == 1);
            if ($urandom_range(399, 0) == 0) begin
                #3 rst = 0;
                step();
                rst = 1;
            end
            step();
        end
        pc_valid_i = 0; flush_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; inst_ready_i = 0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
